axi_sevenseg_mux: RTL and testbench
===================================

Name: axi_sevenseg_mux

Overview:
AXI4-Lite slave that drives a multiplexed common-anode/cathode 7-segment display. It is the parametrised successor of the single-register 7-seg IP. It adds configurable digit count, scan rate, hex-decode or raw-segment modes, a per-digit decimal-point mask, and PWM brightness control. It sits on the PS/PL AXI interconnect as an S00_AXI peripheral and drives board pins directly.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000, clocks per digit slot; must be ≥ 2^PWM_BITS.
- PWM_BITS, 4, brightness resolution.
- SEG_ACTIVE_LOW, 1, 1 inverts the seg and dp pins.
- AN_ACTIVE_LOW, 1, 1 inverts the an pins.
- C_S00_AXI_DATA_WIDTH, 32, fixed at 32.
- C_S00_AXI_ADDR_WIDTH, 4, byte address width.

Ports:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  reset, asynchronous and active-low.
- s00_axi_awaddr/awprot/awvalid/awready  AXI4-Lite write address (in/in/in/out; widths ADDR/3/1/1).
- s00_axi_wdata/wstrb/wvalid/wready  AXI4-Lite write data (in/in/in/out; widths 32/4/1/1).
- s00_axi_bresp/bvalid/bready  AXI4-Lite write response (out/out/in; widths 2/1/1).
- s00_axi_araddr/arprot/arvalid/arready  AXI4-Lite read address (in/in/in/out; widths ADDR/3/1/1).
- s00_axi_rdata/rresp/rvalid/rready  AXI4-Lite read data (out/out/out/in; widths 32/2/1/1).
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- an  out  NUM_DIGITS  digit enables, one-hot when lit.

Behaviour:
- Register map (word aligned):
  - 0x0 DATA: nibble k is the hex value for digit k.
  - 0x4 CTRL: bit0 EN; bit1 RAW; [15:8] DP mask; [19:16] BRIGHT.
  - 0x8 RAW_LO: byte k = {dp,g..a} for digits 0..3.
  - 0xC RAW_HI: byte k = {dp,g..a} for digits 4..7.
- Register access rules:
  - Write strobes are honoured per byte.
  - Unimplemented bits (DATA nibbles ≥ NUM_DIGITS, CTRL[31:20], CTRL[7:2], DP bits ≥ NUM_DIGITS) write-ignore and read 0.
  - All registers reset to 0.
  - bresp and rresp are always OKAY (2'b00).
- Write channel:
  - awready and wready pulse high together for 1 cycle when awvalid&&wvalid&&!bvalid.
  - The register updates on that same edge.
  - bvalid rises the next cycle and holds until bready.
  - Only one write is outstanding; a new write is not accepted while bvalid=1.
- Read channel:
  - arready pulses 1 cycle when arvalid&&!rvalid.
  - rdata is captured on that edge; rvalid rises the next cycle and holds, with rdata stable, until rready.
- Simultaneous read and write are serviced independently. A read accepted in the same cycle as a write to the same register returns the pre-write value.
- Scan timing:
  - Slot counter counts 0..SCAN_DIV-1, then wraps.
  - On wrap, the digit index increments and wraps from NUM_DIGITS-1 to 0.
  - With NUM_DIGITS=1 the index stays at 0.
- PWM:
  - A PWM_BITS-wide counter free-runs.
  - The digit is lit when EN=1 and pwm_cnt ≤ BRIGHT.
  - BRIGHT=15 (max) means always lit; BRIGHT=0 gives a 1/16 duty cycle.
- Segment source:
  - RAW=0: seg = hex decode of the digit's nibble; dp = DP mask bit.
  - RAW=1: seg and dp come from the digit's byte in RAW_LO/RAW_HI.
  - Hex decode values (active-high): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Output registers:
  - seg, dp and an are registered, giving a 1-cycle latency from index/PWM/register change.
  - Polarity inversion is applied at the output register.
  - When unlit, all an bits are inactive and seg/dp are inactive (blank, to prevent ghosting).
- EN=0: outputs are blank; the scan and PWM counters keep running.
- Reset:
  - Assertion at any time, including mid-transaction, asynchronously clears all registers and counters.
  - All ready and valid outputs go to 0.
  - Outputs go to the inactive pin levels: an all 1 and seg/dp all 1 when the active-low parameters are 1.
  - No transaction completes across reset.

Decomposition:
- Package sevenseg_pkg holds:
  - register offsets and CTRL bit positions;
  - RESP_OKAY;
  - the 16-entry hex-to-segment constant table.
- Sub-module sevenseg_scanner owns the slot counter, digit index and PWM counter. It outputs digit_idx and lit.
- The top level contains the AXI slave, the registers and the output mux.

Test Plan:
- Reset pins: release reset, sample before any access → an=FF, seg=7F, dp=1, all AXI valid/ready=0; reads of 0x0/0x4/0x8/0xC return 0.
- Register write/read with strobes: write 0x0=12345678 then wstrb=0001 data FFFFFFAB → read 0x0=123456AB. Write CTRL=FFFFFFFF → read 000FFF03.
- Hex scan: SCAN_DIV=20, DATA=0000000A, CTRL=000F0001 → during digit 0 an=FE and seg=~77=08; digit 1 is lit 20 cycles later with seg=~3F=40; the index wraps after 8 slots.
- Raw mode plus DP: CTRL=000F0003, RAW_HI=80000000 → while digit 7 is lit, seg=7F (blank pattern inverted) and dp=0 (on).
- Brightness: BRIGHT=3, SCAN_DIV=32 → each slot has an active for exactly 8 of 32 cycles (4 per 16-cycle PWM period).
- Handshake stress: hold bready=0 for 10 cycles, issue a second write and a concurrent read → second awready stays 0 until bready; the read completes with the old value.
- Reset mid-write: assert aresetn low while bvalid=1 → bvalid drops immediately; a read of the register after release returns 0.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - register map, response codes and hex segment table for the 7-seg mux
package sevenseg_pkg;

   // Word index of each register (byte address bits [3:2])
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_RAW_LO = 2'd2;
   localparam logic [1:0] ADDR_RAW_HI = 2'd3;

   // CTRL field positions
   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_RAW_BIT    = 1;
   localparam int CTRL_DP_LSB     = 8;
   localparam int CTRL_BRIGHT_LSB = 16;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Active-high {g,f,e,d,c,b,a} patterns, entry 0 in the low slice
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Merge a strobed write into a register, dropping bits that do not exist
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wr_val,
                                               input logic [31:0] byte_en,
                                               input logic [31:0] keep_mask);
      return ((old_val & ~byte_en) | (wr_val & byte_en)) & keep_mask;
   endfunction

endpackage

// File: rtl/sevenseg_scanner.sv
// rtl/sevenseg_scanner.sv - digit slot timer, digit index and brightness PWM
module sevenseg_scanner
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 50000,
   parameter int PWM_BITS   = 4
)(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic [PWM_BITS-1:0] i_bright,
   output logic [2:0]          o_digit_idx,
   output logic                o_lit
);

   localparam int                SLOT_W    = $clog2(SCAN_DIV);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [2:0]        IDX_LAST  = 3'(NUM_DIGITS - 1);

   logic [SLOT_W-1:0]   r_slot_cnt;
   logic [2:0]          r_digit_idx;
   logic [PWM_BITS-1:0] r_pwm_cnt;

   // Slot timer; each wrap hands the display to the next digit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= '0;
      end else if (r_slot_cnt == SLOT_LAST) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= (r_digit_idx == IDX_LAST) ? 3'd0 : r_digit_idx + 3'd1;
      end else begin
         r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
      end
   end

   // Free-running PWM phase, independent of EN so brightness stays phase-locked to the slots
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
   end

   assign o_digit_idx = r_digit_idx;
   assign o_lit       = i_en && (r_pwm_cnt <= i_bright);

endmodule

// File: rtl/axi_sevenseg_mux.sv
// rtl/axi_sevenseg_mux.sv - AXI4-Lite multiplexed 7-segment display driver
module axi_sevenseg_mux
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS           = 8,
   parameter int SCAN_DIV             = 50000,
   parameter int PWM_BITS             = 4,
   parameter int SEG_ACTIVE_LOW       = 1,
   parameter int AN_ACTIVE_LOW        = 1,
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 4
)(
   input  logic                                s00_axi_aclk,
   input  logic                                s00_axi_aresetn,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                          s00_axi_awprot,
   input  logic                                s00_axi_awvalid,
   output logic                                s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                                s00_axi_wvalid,
   output logic                                s00_axi_wready,
   output logic [1:0]                          s00_axi_bresp,
   output logic                                s00_axi_bvalid,
   input  logic                                s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                          s00_axi_arprot,
   input  logic                                s00_axi_arvalid,
   output logic                                s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                          s00_axi_rresp,
   output logic                                s00_axi_rvalid,
   input  logic                                s00_axi_rready,
   output logic [6:0]                          seg,
   output logic                                dp,
   output logic [NUM_DIGITS-1:0]               an
);

   // Bits that exist per register; everything else writes-ignore and reads 0
   localparam logic [31:0] DATA_MASK = 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
   localparam logic [7:0]  DP_MASK   = 8'((1 << NUM_DIGITS) - 1);
   localparam logic [31:0] CTRL_MASK = {12'h000, 4'hF, DP_MASK, 6'h00, 2'b11};

   localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);
   localparam logic [NUM_DIGITS-1:0] AN_INV = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
   localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);

   logic [31:0] r_data, r_ctrl, r_raw_lo, r_raw_hi;
   logic        r_awready, r_bvalid, r_arready, r_rvalid;
   logic [31:0] r_rdata;
   logic [6:0]  r_seg;
   logic        r_dp;
   logic [NUM_DIGITS-1:0] r_an;

   logic        w_wr_fire, w_rd_fire;
   logic [31:0] w_byte_en, w_rd_mux;
   logic [2:0]  w_digit_idx;
   logic        w_lit;
   logic [3:0]  w_nibble;
   logic [31:0] w_raw_word;
   logic [7:0]  w_raw_byte, w_dp_mask;
   logic [6:0]  w_seg_on;
   logic        w_dp_on;
   logic [NUM_DIGITS-1:0] w_an_on;
   logic        w_unused;

   assign w_unused  = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
   assign w_wr_fire = r_awready && s00_axi_awvalid && s00_axi_wvalid;
   assign w_rd_fire = r_arready && s00_axi_arvalid;

   // Expand byte strobes to a bit mask
   always_comb begin
      w_byte_en = '0;
      for (int b = 0; b < 4; b++) begin
         w_byte_en[b*8 +: 8] = {8{s00_axi_wstrb[b]}};
      end
   end

   // Write handshake: single-cycle ready pulse, one response outstanding at a time
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         r_awready <= s00_axi_awvalid && s00_axi_wvalid && !r_bvalid && !r_awready;
         if (w_wr_fire) begin
            r_bvalid <= 1'b1;
         end else if (r_bvalid && s00_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Register file update on the write handshake edge
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_data   <= '0;
         r_ctrl   <= '0;
         r_raw_lo <= '0;
         r_raw_hi <= '0;
      end else if (w_wr_fire) begin
         case (s00_axi_awaddr[3:2])
            ADDR_DATA:   r_data   <= apply_wstrb(r_data,   s00_axi_wdata, w_byte_en, DATA_MASK);
            ADDR_CTRL:   r_ctrl   <= apply_wstrb(r_ctrl,   s00_axi_wdata, w_byte_en, CTRL_MASK);
            ADDR_RAW_LO: r_raw_lo <= apply_wstrb(r_raw_lo, s00_axi_wdata, w_byte_en, 32'hFFFF_FFFF);
            ADDR_RAW_HI: r_raw_hi <= apply_wstrb(r_raw_hi, s00_axi_wdata, w_byte_en, 32'hFFFF_FFFF);
         endcase
      end
   end

   // Read data select; registers hold only implemented bits so no masking needed here
   always_comb begin
      w_rd_mux = '0;
      case (s00_axi_araddr[3:2])
         ADDR_DATA:   w_rd_mux = r_data;
         ADDR_CTRL:   w_rd_mux = r_ctrl;
         ADDR_RAW_LO: w_rd_mux = r_raw_lo;
         ADDR_RAW_HI: w_rd_mux = r_raw_hi;
      endcase
   end

   // Read handshake; capturing with <= gives the pre-write value on a same-edge write
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_arready <= s00_axi_arvalid && !r_rvalid && !r_arready;
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (r_rvalid && s00_axi_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   sevenseg_scanner #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV),
      .PWM_BITS   (PWM_BITS)
   ) u_scanner (
      .i_clk       (s00_axi_aclk),
      .i_rst_n     (s00_axi_aresetn),
      .i_en        (r_ctrl[CTRL_EN_BIT]),
      .i_bright    (r_ctrl[CTRL_BRIGHT_LSB +: PWM_BITS]),
      .o_digit_idx (w_digit_idx),
      .o_lit       (w_lit)
   );

   assign w_nibble   = r_data[{w_digit_idx, 2'b00} +: 4];
   assign w_raw_word = w_digit_idx[2] ? r_raw_hi : r_raw_lo;
   assign w_raw_byte = w_raw_word[{w_digit_idx[1:0], 3'b000} +: 8];
   assign w_dp_mask  = r_ctrl[CTRL_DP_LSB +: 8];
   assign w_seg_on   = r_ctrl[CTRL_RAW_BIT] ? w_raw_byte[6:0] : HEX_SEG[w_nibble];
   assign w_dp_on    = r_ctrl[CTRL_RAW_BIT] ? w_raw_byte[7]   : w_dp_mask[w_digit_idx];
   assign w_an_on    = AN_ONE << w_digit_idx;

   // Pin register: polarity applied here, and a dark phase blanks everything to avoid ghosting
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         r_an  <= AN_INV;
         r_seg <= SEG_INV;
         r_dp  <= DP_INV;
      end else if (w_lit) begin
         r_an  <= w_an_on ^ AN_INV;
         r_seg <= w_seg_on ^ SEG_INV;
         r_dp  <= w_dp_on ^ DP_INV;
      end else begin
         r_an  <= AN_INV;
         r_seg <= SEG_INV;
         r_dp  <= DP_INV;
      end
   end

   assign s00_axi_awready = r_awready;
   assign s00_axi_wready  = r_awready;
   assign s00_axi_bresp   = RESP_OKAY;
   assign s00_axi_bvalid  = r_bvalid;
   assign s00_axi_arready = r_arready;
   assign s00_axi_rdata   = r_rdata;
   assign s00_axi_rresp   = RESP_OKAY;
   assign s00_axi_rvalid  = r_rvalid;
   assign seg             = r_seg;
   assign dp              = r_dp;
   assign an              = r_an;

endmodule

// File: tb/tb_axi_sevenseg_mux.sv
// tb/tb_axi_sevenseg_mux.sv - self-checking bench for the AXI 7-segment mux
module tb_axi_sevenseg_mux;

   logic        clk, rst_n;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid, a_dp;
   logic [1:0]  a_bresp, a_rresp;
   logic [31:0] a_rdata;
   logic [6:0]  a_seg;
   logic [7:0]  a_an;
   logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_dp;
   logic [1:0]  b_bresp, b_rresp;
   logic [31:0] b_rdata;
   logic [6:0]  b_seg;
   logic [7:0]  b_an;

   axi_sevenseg_mux #(.NUM_DIGITS(8), .SCAN_DIV(20), .PWM_BITS(4),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_a (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(a_awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(a_wready),
      .s00_axi_bresp(a_bresp), .s00_axi_bvalid(a_bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(a_arready),
      .s00_axi_rdata(a_rdata), .s00_axi_rresp(a_rresp), .s00_axi_rvalid(a_rvalid), .s00_axi_rready(rready),
      .seg(a_seg), .dp(a_dp), .an(a_an));

   axi_sevenseg_mux #(.NUM_DIGITS(8), .SCAN_DIV(32), .PWM_BITS(4),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_b (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(b_awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(b_wready),
      .s00_axi_bresp(b_bresp), .s00_axi_bvalid(b_bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(b_arready),
      .s00_axi_rdata(b_rdata), .s00_axi_rresp(b_rresp), .s00_axi_rvalid(b_rvalid), .s00_axi_rready(rready),
      .seg(b_seg), .dp(b_dp), .an(b_an));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_pass = 0;
   int n_total = 0;
   logic [31:0] sb_q[$];

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp;
   } reg_vec_t;
   reg_vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic timeout_fail(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_pop_check(input string name, input logic [31:0] act);
      if (sb_q.size() == 0) timeout_fail({name, "_sb_empty"});
      else check(name, act, sb_q.pop_front());
   endtask

   // Completes a write whose valids are already driven
   task automatic finish_write(input string name);
      int n = 0;
      while (!a_awready && n < 20) begin step(); n++; end
      if (n >= 20) timeout_fail({name, "_awready"});
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      n = 0;
      while (!a_bvalid && n < 20) begin step(); n++; end
      if (n >= 20) timeout_fail({name, "_bvalid"});
      bready = 1'b1;
      step();
      bready = 1'b0;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      finish_write("wr");
   endtask

   task automatic axi_read_check(input logic [3:0] addr, input logic [31:0] exp, input string name);
      int n = 0;
      sb_q.push_back(exp);
      araddr = addr; arvalid = 1'b1;
      while (!a_arready && n < 20) begin step(); n++; end
      if (n >= 20) timeout_fail({name, "_arready"});
      step();
      arvalid = 1'b0;
      n = 0;
      while (!a_rvalid && n < 20) begin step(); n++; end
      if (n >= 20) timeout_fail({name, "_rvalid"});
      sb_pop_check(name, a_rdata);
      rready = 1'b1;
      step();
      rready = 1'b0;
   endtask

   int n, run, per, bad;
   int cnt[8];
   bit seen_aw, got_rd, ar_hs, r_hs, found;
   logic [7:0] pat;
   logic [3:0] reg_addr[4];

   initial begin
      vecs[0] = '{4'h0, 32'h1234_5678, 4'hF, 32'h1234_5678};
      vecs[1] = '{4'h0, 32'hFFFF_FFAB, 4'h1, 32'h1234_56AB};
      vecs[2] = '{4'h4, 32'hFFFF_FFFF, 4'hF, 32'h000F_FF03};
      vecs[3] = '{4'h4, 32'h0000_0000, 4'h2, 32'h000F_0003};
      vecs[4] = '{4'h8, 32'hA5A5_5A5A, 4'h6, 32'h00A5_5A00};
      vecs[5] = '{4'hC, 32'h8000_0000, 4'hF, 32'h8000_0000};
      vecs[6] = '{4'h0, 32'h0000_000A, 4'hF, 32'h0000_000A};
      vecs[7] = '{4'h4, 32'h000F_0001, 4'hF, 32'h000F_0001};
      reg_addr[0] = 4'h0; reg_addr[1] = 4'h4; reg_addr[2] = 4'h8; reg_addr[3] = 4'hC;

      rst_n = 1'b0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      wdata = '0; wstrb = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // Reset pin levels and idle handshake
      check("rst_an", a_an, 8'hFF);
      check("rst_seg", a_seg, 7'h7F);
      check("rst_dp", a_dp, 1'b1);
      check("rst_hs", {a_awready, a_wready, a_bvalid, a_arready, a_rvalid}, 5'b0);
      for (int i = 0; i < 4; i++) axi_read_check(reg_addr[i], 32'h0, "rst_read");

      // Strobed register write/read vectors
      for (int i = 0; i < 8; i++) begin
         axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
         axi_read_check(vecs[i].addr, vecs[i].exp, "reg_vec");
      end

      // Hex scan on the 20-clock slot instance: DATA=A, CTRL EN, BRIGHT=15
      n = 0; while (a_an == 8'hFE && n < 400) begin step(); n++; end
      n = 0; while (a_an != 8'hFE && n < 400) begin step(); n++; end
      check("hex_d0_an", a_an, 8'hFE);
      check("hex_d0_seg", a_seg, 7'h08);
      check("hex_d0_dp", a_dp, 1'b1);
      run = 0; while (a_an == 8'hFE && run < 100) begin step(); run++; end
      check("hex_slot_len", run, 20);
      check("hex_d1_an", a_an, 8'hFD);
      check("hex_d1_seg", a_seg, 7'h40);
      per = run; while (a_an != 8'hFE && per < 400) begin step(); per++; end
      check("hex_wrap_period", per, 160);

      // Raw mode: digit 7 gets 0x80 (dp only), digit 1 gets 0x5A
      axi_write(4'h4, 32'h000F_0003, 4'hF);
      n = 0; while (a_an != 8'h7F && n < 400) begin step(); n++; end
      check("raw_d7_an", a_an, 8'h7F);
      check("raw_d7_seg", a_seg, 7'h7F);
      check("raw_d7_dp", a_dp, 1'b0);
      n = 0; while (a_an != 8'hFD && n < 400) begin step(); n++; end
      check("raw_d1_seg", a_seg, 7'h25);
      check("raw_d1_dp", a_dp, 1'b1);

      // EN=0 keeps the pins blank
      axi_write(4'h4, 32'h0000_0002, 4'hF);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (a_an != 8'hFF || a_seg != 7'h7F || a_dp != 1'b1) bad++;
      end
      check("en0_blank", bad, 0);

      // Brightness 3 on the 32-clock slot instance: 8 lit cycles per digit per scan
      axi_write(4'h4, 32'h0003_0001, 4'hF);
      repeat (3) step();
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         if (b_an != 8'hFF) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
               pat = ~(8'd1 << k);
               if (b_an == pat) begin cnt[k]++; found = 1; end
            end
            if (!found) bad++;
         end
      end
      for (int k = 0; k < 8; k++) check("bright_duty", cnt[k], 8);
      check("bright_onehot", bad, 0);

      // Handshake stress: response held, second write and a read overlap
      awaddr = 4'h8; wdata = 32'h1111_1111; wstrb = 4'hF;
      awvalid = 1; wvalid = 1;
      n = 0; while (!a_awready && n < 20) begin step(); n++; end
      step();
      awvalid = 0; wvalid = 0;
      check("stress_bvalid", a_bvalid, 1'b1);
      wdata = 32'h2222_2222; awvalid = 1; wvalid = 1;
      araddr = 4'h8; arvalid = 1;
      sb_q.push_back(32'h1111_1111);
      seen_aw = 0; got_rd = 0;
      for (int i = 0; i < 10; i++) begin
         ar_hs = arvalid && a_arready;
         r_hs  = a_rvalid && rready;
         step();
         if (a_awready) seen_aw = 1;
         if (ar_hs) arvalid = 0;
         if (r_hs) rready = 0;
         if (a_rvalid && !got_rd) begin
            sb_pop_check("stress_read_old", a_rdata);
            got_rd = 1;
            rready = 1;
         end
      end
      rready = 0; arvalid = 0;
      check("stress_aw_blocked", seen_aw, 1'b0);
      check("stress_read_done", got_rd, 1'b1);
      check("stress_bvalid_held", a_bvalid, 1'b1);
      bready = 1;
      step();
      bready = 0;
      check("stress_bvalid_drop", a_bvalid, 1'b0);
      finish_write("stress_wr2");
      axi_read_check(4'h8, 32'h2222_2222, "stress_read_new");

      // Same-edge read and write of one register returns the old value
      awaddr = 4'hC; wdata = 32'h1234_5678; wstrb = 4'hF; araddr = 4'hC;
      awvalid = 1; wvalid = 1; arvalid = 1;
      sb_q.push_back(32'h8000_0000);
      step();
      check("same_ready", {a_awready, a_arready}, 2'b11);
      step();
      awvalid = 0; wvalid = 0; arvalid = 0;
      check("same_valids", {a_bvalid, a_rvalid}, 2'b11);
      sb_pop_check("same_read_old", a_rdata);
      rready = 1; bready = 1;
      step();
      rready = 0; bready = 0;
      axi_read_check(4'hC, 32'h1234_5678, "same_read_new");

      // Reset asserted while a write response is pending
      awaddr = 4'h0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      awvalid = 1; wvalid = 1;
      n = 0; while (!a_awready && n < 20) begin step(); n++; end
      step();
      awvalid = 0; wvalid = 0;
      check("rstmid_bvalid_pre", a_bvalid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_bvalid_async", a_bvalid, 1'b0);
      check("rstmid_an", a_an, 8'hFF);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      axi_read_check(4'h0, 32'h0, "rstmid_read");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
